// File: rtl/morph_filter_if.sv
// morph_filter_if: pixel stream into and out of the 3x3 morphology stage.
interface morph_filter_if;
    logic        frame_start;
    logic        filt_en;
    logic        pi_valid;
    logic [15:0] pi_data;
    logic        po_valid;
    logic [15:0] po_data;
    logic        frame_done;
    modport master (output frame_start, filt_en, pi_valid, pi_data, input po_valid, po_data, frame_done);
    modport slave  (input frame_start, filt_en, pi_valid, pi_data, output po_valid, po_data, frame_done);
endinterface

// File: rtl/morph_filter.sv
// morph_filter: 3x3 binary erosion/dilation on a raster pixel stream, 2-cycle latency.
// Output image is shifted by one row and one column; rows/cols 0-1 of each frame are forced to zero.
module morph_filter #(
    parameter int IMG_W = 800,
    parameter int IMG_H = 480,
    parameter bit MODE  = 1'b0
) (
    input logic           sys_clk,
    input logic           sys_rst,
    morph_filter_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    logic [CW-1:0]    col_q, col_d, cur_col;
    logic [RW-1:0]    row_q, row_d, cur_row;
    logic [IMG_W-1:0] lb0_q, lb0_d, lb1_q, lb1_d;
    logic [8:0]       win_q, win_d;
    logic             s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [15:0]      s1_data_q, s1_data_d;
    logic             po_valid_q, po_valid_d, frame_done_q, frame_done_d;
    logic [15:0]      po_data_q, po_data_d;
    logic             b, hit, border, col_end;
    always_comb begin
        b         = |bus.pi_data;
        cur_col   = bus.frame_start ? '0 : col_q;
        cur_row   = bus.frame_start ? '0 : row_q;
        col_end   = cur_col == CW'(IMG_W - 1);
        col_d     = cur_col;
        row_d     = cur_row;
        lb0_d     = lb0_q;
        lb1_d     = lb1_q;
        win_d     = win_q;
        s1_data_d = s1_data_q;
        s1_last_d = s1_last_q;
        if (bus.pi_valid) begin
            col_d          = col_end ? '0 : cur_col + CW'(1);
            row_d          = !col_end ? cur_row : (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
            lb0_d[cur_col] = lb1_q[cur_col];
            lb1_d[cur_col] = b;
            win_d          = {win_q[5:0], lb0_q[cur_col], lb1_q[cur_col], b};
        end
        hit    = MODE ? |win_d : &win_d;
        border = (cur_row < RW'(2)) || (cur_col < CW'(2));
        if (bus.pi_valid) begin
            s1_data_d = bus.filt_en ? {16{hit && !border}} : bus.pi_data;
            s1_last_d = col_end && (cur_row == RW'(IMG_H - 1));
        end
        s1_valid_d   = bus.pi_valid;
        po_valid_d   = s1_valid_q;
        po_data_d    = s1_valid_q ? s1_data_q : po_data_q;
        frame_done_d = s1_valid_q && s1_last_q;
    end
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            col_q        <= '0;
            row_q        <= '0;
            lb0_q        <= '0;
            lb1_q        <= '0;
            win_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_data_q    <= '0;
            po_valid_q   <= 1'b0;
            po_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            lb0_q        <= lb0_d;
            lb1_q        <= lb1_d;
            win_q        <= win_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_data_q    <= s1_data_d;
            po_valid_q   <= po_valid_d;
            po_data_q    <= po_data_d;
            frame_done_q <= frame_done_d;
        end
    end
    assign bus.po_valid   = po_valid_q;
    assign bus.po_data    = po_data_q;
    assign bus.frame_done = frame_done_q;
endmodule
